// File: rtl/corescore_uart_rx.sv
// UART 8N1 receiver feeding a small AXI-Stream byte FIFO.
// The line is double-flopped and a mid-bit sampler rebuilds each byte.
module corescore_uart_rx #(
    parameter int           BAUD_DIV  = 868,
    parameter int           DEPTH     = 4,
    parameter logic [7:0]   LAST_CHAR = 8'h0A
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic [2:0] o_dbg_state
);

    localparam int TW = $clog2(BAUD_DIV);
    localparam int AW = $clog2(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TIMER_HALF = TW'(BAUD_DIV / 2 - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    idx_q;
    logic [7:0]    shreg_q;
    logic          frame_err_q;
    logic          rx_meta_q;
    logic          rx_s_q;

    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;

    logic          rx_s;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          fifo_full;

    assign rx_s = rx_s_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    if (!rx_s) state_q <= ST_START;
                end
                ST_START: begin
                    // A start bit that is gone by mid-bit was only a glitch.
                    if (timer_q == TIMER_HALF) begin
                        timer_q <= '0;
                        idx_q   <= '0;
                        state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (timer_q == TIMER_LAST) begin
                        timer_q <= '0;
                        shreg_q <= {rx_s, shreg_q[7:1]};
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == 3'd7) state_q <= ST_STOP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (timer_q == TIMER_LAST) begin
                        timer_q <= '0;
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign push_req  = (state_q == ST_STOP) && (timer_q == TIMER_LAST) && rx_s;
    assign fifo_full = (count_q == COUNT_FULL);
    assign do_pop    = (count_q != '0) && i_tready;
    // A full FIFO still takes the byte when the head leaves on the same edge.
    assign do_push   = push_req && (!fifo_full || do_pop);

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = push_req && fifo_full && !do_pop;
        if (do_push) begin
            mem_d[wr_ptr_q] = {(shreg_q == LAST_CHAR), shreg_q};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_tvalid    = (count_q != '0);
    assign o_tdata     = o_tvalid ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign o_tlast     = o_tvalid ? mem_q[rd_ptr_q][8] : 1'b0;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_corescore_uart_rx.sv
// Directed bench for corescore_uart_rx: serial frames in, AXI-Stream beats out.
// A negedge monitor captures beats and error pulses; the main sequence checks them.
module tb_corescore_uart_rx;

    localparam int BAUD = 16;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd2;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_uart_rx = 1'b1;
    logic [7:0] o_tdata;
    logic       o_tlast;
    logic       o_tvalid;
    logic       i_tready = 1'b1;
    logic       o_frame_err;
    logic       o_overrun;
    logic [2:0] o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_idx  = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    int err_base;
    int ovr_base;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    corescore_uart_rx #(
        .BAUD_DIV  (BAUD),
        .DEPTH     (4),
        .LAST_CHAR (8'h0A)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_uart_rx   (i_uart_rx),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .i_tready    (i_tready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_dbg_state (o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_tvalid && i_tready) got_q.push_back({o_tlast, o_tdata});
        if (o_frame_err) err_cnt++;
        if (o_overrun) ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic bit_out(input logic b);
        i_uart_rx = b;
        repeat (BAUD) @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        bit_out(stop_bit);
        i_uart_rx = 1'b1;
    endtask

    task automatic check_beats(input string tag);
        while (exp_q.size() > 0) begin
            logic [8:0] e;
            logic [31:0] obs;
            e = exp_q.pop_front();
            obs = (rd_idx < got_q.size()) ? {23'd0, got_q[rd_idx]} : 32'hDEAD_0000;
            chk(tag, obs, {23'd0, e});
            rd_idx++;
        end
        chk({tag, "_count"}, got_q.size(), rd_idx);
    endtask

    task automatic snap_pulses();
        err_base = err_cnt;
        ovr_base = ovr_cnt;
    endtask

    initial begin
        // Reset state
        idle(3);
        @(negedge i_clk);
        chk("rst_tvalid", o_tvalid, 0);
        chk("rst_tdata", o_tdata, 0);
        chk("rst_tlast", o_tlast, 0);
        chk("rst_ferr", o_frame_err, 0);
        chk("rst_ovr", o_overrun, 0);
        chk("rst_state", o_dbg_state, S_IDLE);
        idle(1);
        i_rst = 1'b0;
        idle(5);

        // 1: single byte 0x55
        snap_pulses();
        send_byte(8'h55, 1'b1);
        idle(20);
        exp_q.push_back({1'b0, 8'h55});
        check_beats("t1_beat");
        chk("t1_ferr", err_cnt - err_base, 0);
        chk("t1_ovr", ovr_cnt - ovr_base, 0);

        // 2: end-of-line byte then a normal byte
        send_byte(8'h0A, 1'b1);
        send_byte(8'h41, 1'b1);
        idle(20);
        exp_q.push_back({1'b1, 8'h0A});
        exp_q.push_back({1'b0, 8'h41});
        check_beats("t2_beat");

        // 3: stalled consumer, fifth byte overruns
        snap_pulses();
        i_tready = 1'b0;
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
        idle(20);
        @(negedge i_clk);
        chk("t3_ovr", ovr_cnt - ovr_base, 1);
        chk("t3_stall_valid", o_tvalid, 1);
        chk("t3_stall_data", o_tdata, 8'h01);
        chk("t3_stall_last", o_tlast, 0);
        chk("t3_no_beats", got_q.size(), rd_idx);
        idle(1);
        i_tready = 1'b1;
        idle(10);
        @(negedge i_clk);
        chk("t3_drained_valid", o_tvalid, 0);
        chk("t3_drained_data", o_tdata, 0);
        for (int b = 1; b <= 4; b++) exp_q.push_back({1'b0, 8'(b)});
        check_beats("t3_beat");
        idle(1);

        // 4: framing error then line held low
        snap_pulses();
        send_byte(8'h33, 1'b0);
        i_uart_rx = 1'b0;
        idle(40);
        i_uart_rx = 1'b1;
        idle(10);
        @(negedge i_clk);
        chk("t4_ferr", err_cnt - err_base, 1);
        chk("t4_ovr", ovr_cnt - ovr_base, 0);
        chk("t4_state", o_dbg_state, S_IDLE);
        chk("t4_no_beat", got_q.size(), rd_idx);
        idle(1);
        send_byte(8'h7E, 1'b1);
        idle(20);
        exp_q.push_back({1'b0, 8'h7E});
        check_beats("t4_beat");
        chk("t4_ferr_after", err_cnt - err_base, 1);

        // 5: short low glitch is rejected
        snap_pulses();
        i_uart_rx = 1'b0;
        idle(6);
        i_uart_rx = 1'b1;
        idle(30);
        @(negedge i_clk);
        chk("t5_state", o_dbg_state, S_IDLE);
        chk("t5_ferr", err_cnt - err_base, 0);
        chk("t5_valid", o_tvalid, 0);
        chk("t5_no_beat", got_q.size(), rd_idx);
        idle(1);

        // 6: reset mid-frame clears FSM and FIFO
        i_tready = 1'b0;
        send_byte(8'h5A, 1'b1);
        idle(10);
        @(negedge i_clk);
        chk("t6_queued_valid", o_tvalid, 1);
        chk("t6_queued_data", o_tdata, 8'h5A);
        idle(1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        @(negedge i_clk);
        chk("t6_mid_state", o_dbg_state, S_DATA);
        idle(1);
        i_rst = 1'b1;
        i_uart_rx = 1'b1;
        idle(2);
        @(negedge i_clk);
        chk("t6_rst_valid", o_tvalid, 0);
        chk("t6_rst_data", o_tdata, 0);
        chk("t6_rst_last", o_tlast, 0);
        chk("t6_rst_state", o_dbg_state, S_IDLE);
        chk("t6_rst_ferr", o_frame_err, 0);
        idle(1);
        i_rst = 1'b0;
        i_tready = 1'b1;
        idle(5);
        @(negedge i_clk);
        chk("t6_post_valid", o_tvalid, 0);
        idle(1);
        snap_pulses();
        send_byte(8'hA5, 1'b1);
        idle(20);
        exp_q.push_back({1'b0, 8'hA5});
        check_beats("t6_beat");
        chk("t6_ferr", err_cnt - err_base, 0);
        chk("t6_ovr", ovr_cnt - ovr_base, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
